// File: rtl/bp_fe_ras_ckpt.sv
// Return-address stack for the front end: circular array, saturating occupancy
// count, and {ptr, count, top} checkpoints that can be restored after a mispredict.
module bp_fe_ras_ckpt #(
  parameter int vaddr_width_p = 39,
  parameter int els_p         = 8,
  localparam int ptr_width    = $clog2(els_p),
  localparam int cnt_width    = $clog2(els_p + 1),
  localparam int ckpt_width   = ptr_width + cnt_width + vaddr_width_p
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     call_i,
  input  logic [vaddr_width_p-1:0] addr_i,
  input  logic                     return_i,
  output logic [vaddr_width_p-1:0] tgt_o,
  output logic                     v_o,
  output logic [ckpt_width-1:0]    ckpt_o,
  input  logic                     restore_v_i,
  input  logic [ckpt_width-1:0]    restore_ckpt_i
);

  localparam logic [cnt_width-1:0] CNT_FULL = cnt_width'(els_p);

  logic [ptr_width-1:0]     r_ptr;
  logic [cnt_width-1:0]     r_cnt;
  logic [vaddr_width_p-1:0] r_mem [els_p];

  logic [ptr_width-1:0]     w_ck_ptr;
  logic [cnt_width-1:0]     w_ck_cnt;
  logic [vaddr_width_p-1:0] w_ck_top;
  logic [ptr_width-1:0]     w_ptr_inc, w_ptr_dec, w_ptr_n, w_waddr;
  logic [cnt_width-1:0]     w_cnt_n;
  logic [vaddr_width_p-1:0] w_wdata;
  logic                     w_we;

  assign w_ck_ptr  = restore_ckpt_i[ckpt_width-1 -: ptr_width];
  assign w_ck_cnt  = restore_ckpt_i[vaddr_width_p+cnt_width-1 -: cnt_width];
  assign w_ck_top  = restore_ckpt_i[vaddr_width_p-1:0];

  // Power-of-two depth: natural ptr_width-bit wrap gives modulo arithmetic.
  assign w_ptr_inc = r_ptr + 1'b1;
  assign w_ptr_dec = r_ptr - 1'b1;

  always_comb begin
    w_ptr_n = r_ptr;
    w_cnt_n = r_cnt;
    w_we    = 1'b0;
    w_waddr = r_ptr;
    w_wdata = addr_i;
    if (restore_v_i) begin
      // Rewriting the top slot undoes a speculative call that clobbered it.
      w_ptr_n = w_ck_ptr;
      w_cnt_n = w_ck_cnt;
      w_we    = (w_ck_cnt != '0);
      w_waddr = w_ck_ptr;
      w_wdata = w_ck_top;
    end else begin
      unique case ({call_i, return_i})
        2'b11: begin
          w_we = 1'b1;
          if (r_cnt == '0) w_cnt_n = cnt_width'(1);
        end
        2'b10: begin
          w_ptr_n = w_ptr_inc;
          w_we    = 1'b1;
          w_waddr = w_ptr_inc;
          if (r_cnt != CNT_FULL) w_cnt_n = r_cnt + 1'b1;
        end
        2'b01: begin
          if (r_cnt != '0) begin
            w_ptr_n = w_ptr_dec;
            w_cnt_n = r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else begin
      r_ptr <= w_ptr_n;
      r_cnt <= w_cnt_n;
    end
  end

  // Storage is left unreset; entries outside the count are never reported valid.
  always_ff @(posedge clk_i) begin
    if (!reset_i && w_we) r_mem[w_waddr] <= w_wdata;
  end

  assign tgt_o  = r_mem[r_ptr];
  assign v_o    = (r_cnt != '0);
  assign ckpt_o = {r_ptr, r_cnt, r_mem[r_ptr]};

endmodule
